// File: rtl/tc_abs_pipe_if.sv
// Ready/valid stream bundle for tc_abs_pipe: input beat (a, sat) and result beat (fs_0, ovf).
// The master side is the surrounding datapath; the slave side is the abs unit.
interface tc_abs_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   a;
    logic                     sat;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   fs_0;
    logic [LANES-1:0]         ovf;

    modport master (
        output in_valid, a, sat, out_ready,
        input  in_ready, out_valid, fs_0, ovf
    );

    modport slave (
        input  in_valid, a, sat, out_ready,
        output in_ready, out_valid, fs_0, ovf
    );
endinterface

// File: rtl/tc_abs_pipe.sv
// Multi-lane two's-complement absolute value behind a LATENCY-deep valid/ready pipeline,
// with per-beat wrap/saturate of MIN and a saturating count of overflowing output beats.
module tc_abs_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LANES   = 1,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [CW-1:0] ovf_count,
    tc_abs_pipe_if.slave  bus
);
    localparam int unsigned DW = LANES * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    logic [DW-1:0]      abs_d;
    logic [LANES-1:0]   ovf_d;
    logic [LATENCY-1:0] rdy;
    logic [LATENCY-1:0] v_vec;
    logic [DW-1:0]      d_all [LATENCY];
    logic [LANES-1:0]   o_all [LATENCY];
    logic [CW-1:0]      cnt_q;
    logic               out_xfer;

    // Per-lane abs; MIN has no positive counterpart so it wraps to itself or clamps to MAX
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] x;
        assign x        = bus.a[l*WIDTH +: WIDTH];
        assign ovf_d[l] = (x == MIN_VAL);
        assign abs_d[l*WIDTH +: WIDTH] =
            !x[WIDTH-1] ? x :
            ovf_d[l]    ? (bus.sat ? MAX_VAL : MIN_VAL) :
                          WIDTH'(~x + WIDTH'(1));
    end

    // Stage s may load when out_ready is high or any stage from s to the tail is empty
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic             up_v;
        logic [DW-1:0]    up_d;
        logic [LANES-1:0] up_o;
        logic             v_q;
        logic [DW-1:0]    d_q;
        logic [LANES-1:0] o_q;

        if (s == 0) begin : g_head
            assign up_v = bus.in_valid;
            assign up_d = abs_d;
            assign up_o = ovf_d;
        end else begin : g_body
            assign up_v = v_vec[s-1];
            assign up_d = d_all[s-1];
            assign up_o = o_all[s-1];
        end

        assign rdy[s] = bus.out_ready || !(&v_vec[LATENCY-1:s]);

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
                o_q <= '0;
            end else if (rdy[s]) begin
                v_q <= up_v;
                if (up_v) begin
                    d_q <= up_d;
                    o_q <= up_o;
                end
            end
        end

        assign v_vec[s] = v_q;
        assign d_all[s] = d_q;
        assign o_all[s] = o_q;
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_vec[LATENCY-1];
    assign bus.fs_0      = d_all[LATENCY-1];
    assign bus.ovf       = o_all[LATENCY-1];

    assign out_xfer = v_vec[LATENCY-1] && bus.out_ready;

    // clr wins over a coincident overflow transfer; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (out_xfer && (|o_all[LATENCY-1]) && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign ovf_count = cnt_q;
endmodule

// File: tb/tb_tc_abs_pipe.sv
// Directed and random checks of tc_abs_pipe at WIDTH=16, LANES=2, LATENCY=3, CW=2.
module tb_tc_abs_pipe;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned LANES   = 2;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned CW      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [CW-1:0] ovf_count;

    tc_abs_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    tc_abs_pipe #(.WIDTH(WIDTH), .LANES(LANES), .LATENCY(LATENCY), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ovf_count (ovf_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fs;
        logic [1:0]  ovf;
        int          stamp;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        sat;
        logic [31:0] fs;
        logic [1:0]  ovf;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[7];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          m_cnt = 0;
    bit          lat_chk = 1'b0;
    bit          last_in_x;
    logic [31:0] cur_fs;
    logic [1:0]  cur_ovf;
    bit          p_stall = 1'b0;
    logic [31:0] p_fs;
    logic [1:0]  p_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent reference: integer magnitude, MIN is the one value whose magnitude does not fit
    task automatic ref_abs(input logic [31:0] av, input logic s,
                           output logic [31:0] r, output logic [1:0] o);
        for (int l = 0; l < 2; l++) begin
            logic [15:0] lane;
            int v, m;
            lane = av[l*16 +: 16];
            v = int'($signed(lane));
            m = (v < 0) ? -v : v;
            if (m == 32768) begin
                o[l] = 1'b1;
                r[l*16 +: 16] = s ? 16'h7FFF : 16'h8000;
            end else begin
                o[l] = 1'b0;
                r[l*16 +: 16] = 16'(m);
            end
        end
    endtask

    // One clock: sample 3 ns before the rising edge, score transfers, then move to the next falling edge
    task automatic tick();
        bit   in_x, out_x;
        exp_t e;
        logic [1:0] e_ovf;
        #2;
        chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
        if (p_stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_fs", 64'(bus.fs_0), 64'(p_fs));
            chk("stall_ovf", 64'(bus.ovf), 64'(p_ovf));
        end
        in_x  = bus.in_valid && bus.in_ready && !rst;
        out_x = bus.out_valid && bus.out_ready && !rst;
        e_ovf = 2'b00;
        if (out_x) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(bus.fs_0), 64'hDEAD);
            end else begin
                e = q.pop_front();
                e_ovf = e.ovf;
                chk("fs_0", 64'(bus.fs_0), 64'(e.fs));
                chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                if (lat_chk) chk("latency", 64'(cyc - e.stamp), 64'(LATENCY));
            end
        end
        if (in_x) begin
            e.fs = cur_fs;
            e.ovf = cur_ovf;
            e.stamp = cyc;
            q.push_back(e);
        end
        if (rst) m_cnt = 0;
        else if (clr) m_cnt = 0;
        else if (out_x && (|e_ovf) && m_cnt < 3) m_cnt++;
        p_stall = bus.out_valid && !bus.out_ready && !rst;
        p_fs = bus.fs_0;
        p_ovf = bus.ovf;
        if (rst) q.delete();
        last_in_x = in_x;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] av, input logic s,
                         input logic [31:0] fs, input logic [1:0] o);
        bus.a = av;
        bus.sat = s;
        cur_fs = fs;
        cur_ovf = o;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] av, input logic s,
                        input logic [31:0] fs, input logic [1:0] o);
        drive(av, s, fs, o);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_in_x) break;
        end
        chk("send_accept", 64'(last_in_x), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        int idx, acc;
        logic [15:0] bp_in [6];
        logic [15:0] bp_out[6];
        logic [31:0] ra, rf;
        logic [1:0]  ro;
        logic        rs;

        vecs[0] = '{32'h0001_FF16, 1'b0, 32'h0001_00EA, 2'b00};
        vecs[1] = '{32'h0000_8000, 1'b0, 32'h0000_8000, 2'b01};
        vecs[2] = '{32'h0000_8000, 1'b1, 32'h0000_7FFF, 2'b01};
        vecs[3] = '{32'h8000_7FFF, 1'b1, 32'h7FFF_7FFF, 2'b10};
        vecs[4] = '{32'hFFFF_0001, 1'b0, 32'h0001_0001, 2'b00};
        vecs[5] = '{32'h8001_7FFF, 1'b1, 32'h7FFF_7FFF, 2'b00};
        vecs[6] = '{32'h8000_8000, 1'b0, 32'h8000_8000, 2'b11};
        bp_in  = '{16'h0000, 16'hFFFF, 16'h0002, 16'hFFFD, 16'h0004, 16'hFFFB};
        bp_out = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.sat = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_fs_0", 64'(bus.fs_0), 64'(0));
        chk("rst_ovf", 64'(bus.ovf), 64'(0));
        chk("rst_ovf_count", 64'(ovf_count), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        // Table vectors, back to back with out_ready high; four of them overflow
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) send(vecs[i].a, vecs[i].sat, vecs[i].fs, vecs[i].ovf);
        drain();
        lat_chk = 1'b0;
        chk("cnt_saturated", 64'(ovf_count), 64'(3));

        // clr coincident with an overflow output transfer
        send(32'h0000_8000, 1'b1, 32'h0000_7FFF, 2'b01);
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        chk("clr_wait_valid", 64'(bus.out_valid), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("cnt_cleared", 64'(ovf_count), 64'(0));

        // Back-pressure: six beats against a 5-cycle stall
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idx = 0;
        for (int t = 0; t < 40 && idx < 6; t++) begin
            bus.out_ready = (t >= 5);
            if (t == 3) chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            drive({16'h0000, bp_in[idx]}, 1'b0, {16'h0000, bp_out[idx]}, 2'b00);
            tick();
            if (last_in_x) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'(6));
        drain();

        // Reset with three beats in flight after one counted overflow
        bus.out_ready = 1'b1;
        send(32'h0000_8000, 1'b0, 32'h0000_8000, 2'b01);
        drain();
        chk("pre_rst_count", 64'(ovf_count), 64'(1));
        bus.out_ready = 1'b0;
        send(32'h0000_0005, 1'b0, 32'h0000_0005, 2'b00);
        send(32'h0000_0006, 1'b0, 32'h0000_0006, 2'b00);
        send(32'h0000_0007, 1'b0, 32'h0000_0007, 2'b00);
        rst = 1'b1;
        drive(32'h0000_0009, 1'b0, 32'h0000_0009, 2'b00);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_ovf_count", 64'(ovf_count), 64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        @(negedge clk);
        repeat (10) tick();

        // Random traffic against the reference model
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            for (int l = 0; l < 2; l++)
                ra[l*16 +: 16] = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            rs = 1'($urandom);
            ref_abs(ra, rs, rf, ro);
            drive(ra, rs, rf, ro);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            tick();
            if (last_in_x) acc++;
        end
        bus.in_valid = 1'b0;
        clr = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_beats", 64'(acc), 64'(10000));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tc_abs_pipe.md
# tc_abs_pipe

Parametrised, pipelined two's-complement absolute-value unit: the next generation of the combinational 16-bit abs block. It processes LANES independent WIDTH-bit lanes per beat through a LATENCY-deep valid/ready pipeline. A per-beat mode selects wrap or saturate handling of the most-negative input. A saturating counter records how many output beats carried an overflow. It sits between SFGen-generated datapath stages that use ready/valid flow control.

## Interface
- WIDTH, 16: bits per lane, two's complement; legal range ≥2.
- LANES, 1: number of lanes per beat; legal range ≥1.
- LATENCY, 2: pipeline register stages; legal range ≥1.
- CW, 8: width of ovf_count.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present on a/sat.
- in_ready  out  1  unit accepts the beat this cycle.
- a  in  LANES*WIDTH  input lanes; lane i is a[i*WIDTH +: WIDTH].
- sat  in  1  mode for this beat: 0 = wrap, 1 = saturate.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- fs_0  out  LANES*WIDTH  abs results, packed the same way as a.
- ovf  out  LANES  per-lane flag: the input lane was the most-negative value (MIN = 1 followed by WIDTH-1 zeros).
- clr  in  1  clears ovf_count.
- ovf_count  out  CW  count of output transfers with any ovf bit set.

## Operation
- Transfer rules:
  - Input transfer: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready on a rising edge.
- Arithmetic per lane, computed before stage-1 register:
  - x ≥ 0: result is x.
  - x < 0 and x ≠ MIN: result is (~x)+1, truncated to WIDTH.
  - x = MIN, sat=0: result is MIN, ovf=1.
  - x = MIN, sat=1: result is MAX (0 followed by WIDTH-1 ones), ovf=1.
  - All other inputs: ovf=0.
- sat is sampled with its beat and applies only to that beat. Lanes are fully independent.
- Pipeline: stages 1..LATENCY, each holding valid bit v[s], data and ovf.
  - Stage s is ready when !v[s] || ready[s+1]. For the last stage, ready[LATENCY+1] = out_ready.
  - in_ready = ready[1].
  - out_valid = v[LATENCY]. fs_0 and ovf are driven from stage LATENCY.
  - Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- ovf_count, in priority order:
  - rst → 0.
  - else clr → 0; a coincident overflow transfer is not counted.
  - else an output transfer with |ovf → +1, saturating at 2^CW-1 (no wrap).
  - otherwise it holds.
- Beat ordering is strictly preserved. No beat is dropped or duplicated except by rst.

## Timing
- Reset values:
  - All v[s] = 0, so out_valid = 0.
  - fs_0 = 0, ovf = 0, ovf_count = 0.
  - in_ready = 1 in the first cycle after reset.
- Latency: a beat accepted on edge k, with out_ready held high, shows out_valid=1 during the cycle after edge k+LATENCY-1. The output transfer happens on edge k+LATENCY.
- Throughput: 1 beat per cycle with out_ready=1. Full occupancy is LATENCY beats.
- Stall: while out_valid=1 && out_ready=0, fs_0 and ovf hold stable. The pipeline fills, after which in_ready=0.
- Release from full: in_ready rises in the same cycle out_ready rises (combinational ready chain). No cycle is lost.
- Combinational paths:
  - in_ready depends on out_ready.
  - No path exists from a or sat to any output.
- Reset mid-stream: on the rst edge all in-flight beats are discarded and ovf_count is cleared. Any input presented on that edge is not accepted.
- in_valid may drop without a transfer (no hold obligation on the source). out_valid never drops without an output transfer or rst.

## Test plan
(WIDTH=16, LANES=2, LATENCY=3.)
- Basic, out_ready=1:
  - Stimulus: a = {16'd1, -16'd234}, sat=0, accepted at edge k.
  - Response: fs_0 = {16'd1, 16'd234}, ovf = 2'b00, output transfer on edge k+3.
- MIN handling:
  - Stimulus: lane0 = 16'h8000, once with sat=0 and once with sat=1.
  - Response: fs_0 lane0 = 16'h8000 then 16'h7FFF; ovf[0] = 1 both times; ovf_count = 2.
- Back-pressure:
  - Stimulus: 6 consecutive beats with values 0, -1, 2, -3, 4, -5; hold out_ready=0 for 5 cycles, then 1.
  - Response: in_ready falls after 3 beats are accepted; outputs are 0, 1, 2, 3, 4, 5 in order with no loss; fs_0 is stable throughout the stall.
- Counter:
  - Stimulus: CW=2, 5 overflow beats; then clr asserted in the same cycle as a 6th overflow transfer.
  - Response: ovf_count saturates at 3, then goes to 0.
- Reset mid-stream:
  - Stimulus: assert rst with 3 beats in flight.
  - Response: the next cycle has out_valid=0, ovf_count=0, in_ready=1, and no stale beat ever emerges.
- Random check:
  - Stimulus: random valid/ready toggling over 10k beats.
  - Response: each output equals the reference abs/ovf model, in order.
